// File: rtl/mux_arb_param.sv
// N-input arbitrated mux with a one-beat registered output stage; round-robin by default,
// fixed lowest-index priority when MUX_ARB_FIXED_PRIO_EN is defined.
module mux_arb_param #(
   parameter int NUM_INPUT  = 4,
   parameter int SEL_WIDTH  = 2,
   parameter int DATA_WIDTH = 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [DATA_WIDTH*NUM_INPUT-1:0] data_in,
   input  logic [NUM_INPUT-1:0]            valid_in,
   output logic [NUM_INPUT-1:0]            ready_out,
   output logic [DATA_WIDTH-1:0]           data_out,
   output logic                            valid_out,
   input  logic                            ready_in,
   output logic [SEL_WIDTH-1:0]            sel_out
);

   localparam int IW = SEL_WIDTH + 1;

   logic                  load;
   logic                  grant_found;
   logic [SEL_WIDTH-1:0]  grant_idx;
   logic [DATA_WIDTH-1:0] grant_data;

   assign load = !valid_out || ready_in;

`ifdef MUX_ARB_FIXED_PRIO_EN
   // Scan from the top down so the lowest valid index is the last writer.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = NUM_INPUT - 1; i >= 0; i--) begin
         if (valid_in[i]) begin
            grant_found = 1'b1;
            grant_idx   = SEL_WIDTH'(i);
         end
      end
   end
`else
   logic [SEL_WIDTH-1:0] last_grant;
   logic [IW-1:0]        cand;

   // One spare bit in cand: last_grant + k + 1 never exceeds 2*NUM_INPUT-1, so a single wrap suffices.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < NUM_INPUT; k++) begin
         cand = IW'(last_grant) + IW'(k + 1);
         if (cand >= IW'(NUM_INPUT)) begin
            cand = cand - IW'(NUM_INPUT);
         end
         for (int i = 0; i < NUM_INPUT; i++) begin
            if (!grant_found && (cand == IW'(i)) && valid_in[i]) begin
               grant_found = 1'b1;
               grant_idx   = SEL_WIDTH'(i);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= SEL_WIDTH'(NUM_INPUT - 1);
      end else if (load && grant_found) begin
         last_grant <= grant_idx;
      end
   end
`endif

   always_comb begin
      grant_data = '0;
      for (int i = 0; i < NUM_INPUT; i++) begin
         if (grant_idx == SEL_WIDTH'(i)) begin
            grant_data = data_in[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // rst_n gates ready_out so no upstream channel sees an accept while in reset.
   always_comb begin
      ready_out = '0;
      for (int i = 0; i < NUM_INPUT; i++) begin
         ready_out[i] = rst_n && load && grant_found && (grant_idx == SEL_WIDTH'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_out <= 1'b0;
         data_out  <= '0;
         sel_out   <= '0;
      end else if (load) begin
         if (grant_found) begin
            valid_out <= 1'b1;
            data_out  <= grant_data;
            sel_out   <= grant_idx;
         end else begin
            valid_out <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_arb_param.sv
// Bench for mux_arb_param: directed scenarios plus random traffic against a behavioural model.
module tb_mux_arb_param;

   localparam int N  = 4;
   localparam int SW = 2;
   localparam int DW = 8;

   logic            clk;
   logic            rst_n;
   logic [DW*N-1:0] data_in;
   logic [N-1:0]    valid_in;
   logic [N-1:0]    ready_out;
   logic [DW-1:0]   data_out;
   logic            valid_out;
   logic            ready_in;
   logic [SW-1:0]   sel_out;

   int n_checks = 0;
   int n_errors = 0;

   mux_arb_param #(.NUM_INPUT(N), .SEL_WIDTH(SW), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .data_out  (data_out),
      .valid_out (valid_out),
      .ready_in  (ready_in),
      .sel_out   (sel_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: output beat register plus the last granted channel.
   logic          m_valid;
   logic [DW-1:0] m_data;
   int            m_sel;
   int            m_last;

   function automatic int pick(input logic [N-1:0] v, input int last);
`ifdef MUX_ARB_FIXED_PRIO_EN
      for (int i = 0; i < N; i++) if (v[i]) return i;
`else
      for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
`endif
      return -1;
   endfunction

   function automatic logic [DW-1:0] chan(input logic [DW*N-1:0] d, input int i);
      return DW'(d >> (i * DW));
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_sel   <= 0;
         m_last  <= N - 1;
      end else if (!m_valid || ready_in) begin
         if (pick(valid_in, m_last) >= 0) begin
            m_valid <= 1'b1;
            m_data  <= chan(data_in, pick(valid_in, m_last));
            m_sel   <= pick(valid_in, m_last);
            m_last  <= pick(valid_in, m_last);
         end else begin
            m_valid <= 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] exp_ready();
      int g;
      if (!rst_n) return '0;
      g = pick(valid_in, m_last);
      if ((!m_valid || ready_in) && g >= 0) return N'(1 << g);
      return '0;
   endfunction

   always @(negedge clk) begin
      chk("cmp_valid_out", 32'(valid_out), 32'(m_valid));
      chk("cmp_data_out", 32'(data_out), 32'(m_data));
      chk("cmp_sel_out", 32'(sel_out), 32'(m_sel));
      chk("cmp_ready_out", 32'(ready_out), 32'(exp_ready()));
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic fixed_data();
      for (int i = 0; i < N; i++) data_in[i*DW +: DW] = DW'(8'hA0 + i);
   endtask

   initial begin
      rst_n    = 1'b0;
      valid_in = 4'b1111;
      ready_in = 1'b1;
      fixed_data();
      step();
      step();
      chk("rst_valid_out", 32'(valid_out), 32'h0);
      chk("rst_data_out", 32'(data_out), 32'h0);
      chk("rst_sel_out", 32'(sel_out), 32'h0);
      chk("rst_ready_out", 32'(ready_out), 32'h0);
      rst_n = 1'b1;

`ifdef MUX_ARB_FIXED_PRIO_EN
      valid_in = 4'b0110;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("fixed_sel", 32'(sel_out), 32'd1);
         chk("fixed_data", 32'(data_out), 32'hA1);
      end
`else
      for (int k = 0; k < 5; k++) begin
         step();
         chk("rot_sel", 32'(sel_out), 32'(k % 4));
         chk("rot_data", 32'(data_out), 32'(8'hA0 + (k % 4)));
         chk("rot_valid", 32'(valid_out), 32'h1);
      end

      // Reset with a beat held; the next grant restarts from channel 0.
      ready_in = 1'b0;
      #1 rst_n = 1'b0;
      #1 chk("midrst_valid_out", 32'(valid_out), 32'h0);
      ready_in = 1'b1;
      valid_in = 4'b1001;
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("wrap_sel", 32'(sel_out), (k % 2 == 0) ? 32'd0 : 32'd3);
      end

      valid_in = 4'b0010;
      step();
      chk("bp_first_data", 32'(data_out), 32'hA1);
      valid_in = 4'b1111;
      ready_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("bp_hold_data", 32'(data_out), 32'hA1);
         chk("bp_hold_valid", 32'(valid_out), 32'h1);
         chk("bp_hold_ready", 32'(ready_out), 32'h0);
      end
      ready_in = 1'b1;
      #1 chk("bp_release_ready", 32'(ready_out), 32'b0100);
      step();
      chk("bp_next_sel", 32'(sel_out), 32'd2);
      chk("bp_next_data", 32'(data_out), 32'hA2);

      valid_in = 4'b0000;
      step();
      chk("idle_valid", 32'(valid_out), 32'h0);
      chk("idle_data", 32'(data_out), 32'hA2);
`endif

      for (int c = 0; c < 2000; c++) begin
         data_in  = {$urandom(), $urandom()} >> 32;
         valid_in = N'($urandom_range(0, 15));
         ready_in = ($urandom_range(0, 3) != 0);
         if (c == 1000) rst_n = 1'b0;
         if (c == 1003) rst_n = 1'b1;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mux_arb_param.md
MUX_ARB_PARAM -- requirements
Module: mux_arb_param

Interface
REQ-001 The block SHALL have parameter NUM_INPUT, default 4, number of input channels (>=2).
REQ-002 The block SHALL have parameter SEL_WIDTH, default 2, grant index width (2^SEL_WIDTH >= NUM_INPUT).
REQ-003 The block SHALL have parameter DATA_WIDTH, default 1, bits per channel.
REQ-004 The block SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port data_in, input, DATA_WIDTH*NUM_INPUT, channel i at data_in[i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 The block SHALL have port valid_in, input, NUM_INPUT, per-channel request.
REQ-008 The block SHALL have port ready_out, output, NUM_INPUT, per-channel accept (combinational).
REQ-009 The block SHALL have port data_out, output, DATA_WIDTH, registered selected data.
REQ-010 The block SHALL have port valid_out, output, 1, data_out holds an unconsumed beat.
REQ-011 The block SHALL have port ready_in, input, 1, downstream accept.
REQ-012 The block SHALL have port sel_out, output, SEL_WIDTH, registered index of the channel that supplied data_out.

Function
REQ-013 The block SHALL assert load = !valid_out || ready_in; a transfer on channel i occurs when valid_in[i] && ready_out[i].
REQ-014 The block SHALL assert ready_out[i] only when load is 1, valid_in[i] is 1 and i is the granted index; at most one ready_out bit SHALL be 1 per cycle.
REQ-015 The block SHALL grant round-robin: search starts at (last_grant+1) mod NUM_INPUT, wrapping at NUM_INPUT-1 to 0, first valid channel wins.
REQ-016 On a transfer the block SHALL register data_out = data_in[grant], sel_out = grant, valid_out = 1 and last_grant = grant, giving 1-cycle latency.
REQ-017 When load is 1 and no valid_in bit is set, the block SHALL clear valid_out and hold data_out, sel_out and last_grant.
REQ-018 While valid_out && !ready_in, the block SHALL hold data_out, sel_out, valid_out and last_grant stable and drive ready_out to 0.
REQ-019 Simultaneous downstream consume and new grant in the same cycle SHALL give full throughput of one beat per cycle.
REQ-020 The block SHALL ignore valid_in bits at or above NUM_INPUT; indices >= NUM_INPUT SHALL never be granted.

Reset
REQ-021 While rst_n is 0, the block SHALL force valid_out=0, data_out=0, sel_out=0, last_grant=NUM_INPUT-1 (first search starts at channel 0), and ready_out=0.
REQ-022 Reset asserted mid-transfer SHALL drop the held beat; the first grant after release SHALL follow REQ-015 from channel 0.

Configuration
REQ-023 With macro MUX_ARB_FIXED_PRIO_EN defined, the block SHALL replace round-robin with fixed priority (lowest valid index wins, last_grant unused); without it, REQ-015 applies.

Verification (NUM_INPUT=4, SEL_WIDTH=2, DATA_WIDTH=8, data_in channel i = 8'hA0+i)
REQ-024 The bench SHALL check reset: rst_n=0 with valid_in=4'b1111 -> valid_out=0, data_out=0, sel_out=0, ready_out=0.
REQ-025 The bench SHALL check rotation: valid_in=4'b1111, ready_in=1 for 5 cycles -> sel_out 0,1,2,3,0 and data_out A0,A1,A2,A3,A0, one per cycle.
REQ-026 The bench SHALL check skip and wrap: valid_in=4'b1001, ready_in=1 -> sel_out alternates 0,3,0,3.
REQ-027 The bench SHALL check backpressure: beat A1 held with ready_in=0 for 3 cycles -> data_out=A1, valid_out=1, ready_out=0 throughout; ready_in=1 -> next grant is channel 2.
REQ-028 The bench SHALL check idle: valid_in=0, ready_in=1 after beat A2 -> valid_out=0 next cycle, data_out stays A2.
REQ-029 The bench SHALL check the MUX_ARB_FIXED_PRIO_EN build: valid_in=4'b0110 held, ready_in=1 -> sel_out stays 1 every cycle.
